// File: rtl/spi_reg_bridge.sv
// SPI-to-register bridge: first frame byte is a command (bit7 read, low bits start address),
// following bytes are burst writes or dummy bytes clocking out burst reads.
module spi_reg_bridge #(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [7:0]        byte_out,
  input  logic [7:0]        status_in,
  output logic [ADDR_W-1:0] reg_raddr,
  input  logic [7:0]        reg_rdata,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [7:0]        reg_wdata,
  output logic              frame_done,
  output logic [7:0]        frame_bytes
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    SKIP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              fa_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        frame_bytes_q, frame_bytes_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              frame_done_q, frame_done_d;

  logic              rise, fall, in_frame, bv_ok;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cnt_inc;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS);
  endfunction

  assign cmd_addr = byte_in[ADDR_W-1:0];
  assign rise     = frame_active & ~fa_q;
  assign fall     = ~frame_active & fa_q;
  assign in_frame = (state_q == CMD) || (state_q == WRITE) || (state_q == READ);
  // A byte arriving in the same cycle as deselect still belongs to the frame.
  assign bv_ok    = byte_valid & in_frame & (frame_active | fall);
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'h01;

  // State and datapath registers; fa_q resets high so a frame held across reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fa_q          <= 1'b1;
      addr_q        <= '0;
      byte_out_q    <= 8'h00;
      cnt_q         <= 8'h00;
      frame_bytes_q <= 8'h00;
      reg_we_q      <= 1'b0;
      reg_waddr_q   <= '0;
      reg_wdata_q   <= 8'h00;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fa_q          <= frame_active;
      addr_q        <= addr_d;
      byte_out_q    <= byte_out_d;
      cnt_q         <= cnt_d;
      frame_bytes_q <= frame_bytes_d;
      reg_we_q      <= reg_we_d;
      reg_waddr_q   <= reg_waddr_d;
      reg_wdata_q   <= reg_wdata_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Next-state logic; SKIP and unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = CMD;
        else      state_d = IDLE;
      end
      CMD: begin
        if (fall)       state_d = IDLE;
        else if (bv_ok) state_d = byte_in[7] ? READ : WRITE;
        else            state_d = CMD;
      end
      WRITE: begin
        if (fall) state_d = IDLE;
        else      state_d = WRITE;
      end
      READ: begin
        if (fall) state_d = IDLE;
        else      state_d = READ;
      end
      SKIP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: address walk, write strobe, response byte, frame accounting.
  always_comb begin
    addr_d        = addr_q;
    byte_out_d    = byte_out_q;
    cnt_d         = cnt_q;
    frame_bytes_d = frame_bytes_q;
    reg_we_d      = 1'b0;
    reg_waddr_d   = reg_waddr_q;
    reg_wdata_d   = reg_wdata_q;
    frame_done_d  = 1'b0;
    if ((state_q == IDLE) && rise) begin
      byte_out_d = status_in;
      cnt_d      = 8'h00;
    end else if (bv_ok) begin
      cnt_d = cnt_inc;
      case (state_q)
        CMD: begin
          // Read bursts preload the first register now, so the walk resumes one ahead.
          if (byte_in[7]) begin
            addr_d     = cmd_addr + ADDR_W'(1);
            byte_out_d = is_mapped(cmd_addr) ? reg_rdata : 8'h00;
          end else begin
            addr_d     = cmd_addr;
            byte_out_d = 8'h00;
          end
        end
        WRITE: begin
          reg_we_d    = is_mapped(addr_q);
          reg_waddr_d = addr_q;
          reg_wdata_d = byte_in;
          addr_d      = addr_q + ADDR_W'(1);
          byte_out_d  = 8'h00;
        end
        READ: begin
          byte_out_d = is_mapped(addr_q) ? reg_rdata : 8'h00;
          addr_d     = addr_q + ADDR_W'(1);
        end
        default: begin
          byte_out_d = 8'h00;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
    if (fall && in_frame) begin
      frame_done_d  = 1'b1;
      frame_bytes_d = cnt_d;
      byte_out_d    = status_in;
    end else begin
      frame_done_d  = 1'b0;
    end
  end

  assign reg_raddr   = (state_q == CMD) ? cmd_addr : addr_q;
  assign byte_out    = byte_out_q;
  assign reg_we      = reg_we_q;
  assign reg_waddr   = reg_waddr_q;
  assign reg_wdata   = reg_wdata_q;
  assign frame_done  = frame_done_q;
  assign frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed and randomized frames against a transaction-level model of the bridge
// (register image plus address arithmetic), with an attached combinational register file.
module tb_spi_reg_bridge;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_active;
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic [7:0]        byte_out;
  logic [7:0]        status_in;
  logic [ADDR_W-1:0] reg_raddr;
  logic [7:0]        reg_rdata;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_waddr;
  logic [7:0]        reg_wdata;
  logic              frame_done;
  logic [7:0]        frame_bytes;

  logic [7:0] env_mem   [64];
  logic [7:0] model_mem [64];
  logic [7:0] data_q [$];
  int checks   = 0;
  int failures = 0;

  spi_reg_bridge #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active), .byte_valid(byte_valid),
    .byte_in(byte_in), .byte_out(byte_out), .status_in(status_in),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .frame_done(frame_done),
    .frame_bytes(frame_bytes)
  );

  always #5 clk = ~clk;

  assign reg_rdata = env_mem[reg_raddr];

  function automatic bit mapped(input int a);
    return a < NUM_REGS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, and the register file commits writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reg_we === 1'b1) env_mem[reg_waddr] = reg_wdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_out"},    byte_out,    32'h0);
    check({tag, "_reg_we"},      reg_we,      32'h0);
    check({tag, "_reg_waddr"},   reg_waddr,   32'h0);
    check({tag, "_reg_wdata"},   reg_wdata,   32'h0);
    check({tag, "_frame_done"},  frame_done,  32'h0);
    check({tag, "_frame_bytes"}, frame_bytes, 32'h0);
  endtask

  // Plays data_q (command first) as one frame; simul drops select together with the last byte.
  task automatic run_frame(input bit simul, input int gapmax);
    logic [7:0] cmd, b, st, exp_out, fb;
    int start, n, a, g;
    bit is_read, last, exp_we;
    cmd     = data_q[0];
    n       = data_q.size();
    start   = int'(cmd[ADDR_W-1:0]);
    is_read = cmd[7];
    fb      = (n > 255) ? 8'hFF : 8'(n);
    st      = 8'($urandom);
    status_in    = st;
    frame_active = 1'b1;
    tick();
    check("frame_start_status", byte_out, st);
    for (int k = 0; k < n; k++) begin
      b    = data_q[k];
      last = (k == n - 1);
      byte_valid = 1'b1;
      byte_in    = b;
      if (simul && last) frame_active = 1'b0;
      exp_we  = 1'b0;
      exp_out = 8'h00;
      a       = 0;
      if (k == 0) begin
        if (is_read && mapped(start)) exp_out = model_mem[start];
      end else if (!is_read) begin
        a      = (start + k - 1) % 64;
        exp_we = mapped(a);
        if (exp_we) model_mem[a] = b;
      end else begin
        a = (start + k) % 64;
        if (mapped(a)) exp_out = model_mem[a];
      end
      if (simul && last) exp_out = st;
      tick();
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      check("reg_we", reg_we, exp_we);
      if (exp_we) begin
        check("reg_waddr", reg_waddr, a);
        check("reg_wdata", reg_wdata, b);
      end
      check("byte_out", byte_out, exp_out);
      if (!last) begin
        g = $urandom_range(gapmax, 0);
        for (int j = 0; j < g; j++) begin
          tick();
          check("gap_reg_we", reg_we, 32'h0);
        end
      end
    end
    if (!simul) begin
      frame_active = 1'b0;
      tick();
      check("end_byte_out_status", byte_out, st);
    end
    check("frame_done_pulse", frame_done, 32'h1);
    check("frame_bytes", frame_bytes, fb);
    tick();
    check("frame_done_clear", frame_done, 32'h0);
    check("frame_bytes_hold", frame_bytes, fb);
    check("post_frame_reg_we", reg_we, 32'h0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    rst_n        = 1'b0;
    frame_active = 1'b1;
    byte_valid   = 1'b0;
    byte_in      = 8'h00;
    status_in    = 8'hA5;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      env_mem[i]   = v;
      model_mem[i] = v;
    end
    tick();
    tick();
    check_reset_outputs("reset");

    // Select already active when reset releases: frame ignored until deselected.
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_in    = (i == 0) ? 8'h02 : 8'($urandom);
      tick();
      byte_valid = 1'b0;
      check("held_frame_no_we", reg_we, 32'h0);
      check("held_frame_byte_out", byte_out, 32'h0);
    end
    frame_active = 1'b0;
    tick();
    check("held_frame_no_done", frame_done, 32'h0);
    tick();

    // Write burst to 5,6.
    data_q.delete();
    data_q.push_back(8'h05); data_q.push_back(8'hAA); data_q.push_back(8'hBB);
    run_frame(1'b0, 1);

    // Read burst from 10,11.
    env_mem[10] = 8'h11; model_mem[10] = 8'h11;
    env_mem[11] = 8'h22; model_mem[11] = 8'h22;
    data_q.delete();
    data_q.push_back(8'h8A); data_q.push_back(8'h00); data_q.push_back(8'h00);
    run_frame(1'b0, 2);

    // Address wrap from 63 (unmapped here) to 0.
    data_q.delete();
    data_q.push_back(8'h3F); data_q.push_back(8'h01); data_q.push_back(8'h02);
    run_frame(1'b0, 0);

    // Unmapped read and write.
    data_q.delete();
    data_q.push_back(8'hB0); data_q.push_back(8'h00);
    run_frame(1'b0, 1);
    data_q.delete();
    data_q.push_back(8'h30); data_q.push_back(8'h55); data_q.push_back(8'h66);
    run_frame(1'b0, 1);

    // Last byte coincident with deselect.
    data_q.delete();
    data_q.push_back(8'h07); data_q.push_back(8'h9C); data_q.push_back(8'h3D);
    run_frame(1'b1, 1);

    // Reset in the middle of a write burst with select held high.
    status_in    = 8'h3C;
    frame_active = 1'b1;
    tick();
    byte_valid = 1'b1; byte_in = 8'h14;
    tick();
    byte_valid = 1'b1; byte_in = 8'h5A;
    model_mem[20] = 8'h5A;
    tick();
    byte_valid = 1'b0;
    check("midreset_pre_we", reg_we, 32'h1);
    check("midreset_pre_waddr", reg_waddr, 32'd20);
    check("midreset_pre_wdata", reg_wdata, 32'h5A);
    rst_n = 1'b0; byte_valid = 1'b1; byte_in = 8'h77;
    tick();
    rst_n = 1'b1; byte_valid = 1'b0;
    check_reset_outputs("midreset");
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      tick();
      byte_valid = 1'b0;
      check("midreset_no_we", reg_we, 32'h0);
      check("midreset_byte_out", byte_out, 32'h0);
    end
    frame_active = 1'b0;
    tick();
    check("midreset_no_done", frame_done, 32'h0);
    check("midreset_frame_bytes", frame_bytes, 32'h0);
    tick();

    // Randomized frames.
    for (int r = 0; r < 24; r++) begin
      int nd;
      data_q.delete();
      data_q.push_back(8'($urandom));
      nd = $urandom_range(5, 0);
      for (int j = 0; j < nd; j++) data_q.push_back(8'($urandom));
      run_frame(1'($urandom_range(1, 0)), 2);
    end

    // Long read burst: byte count saturates.
    data_q.delete();
    data_q.push_back(8'h80);
    for (int j = 0; j < 259; j++) data_q.push_back(8'h00);
    run_frame(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, register address width.
REQ-002 SHALL have parameter NUM_REGS, default 48, implemented registers; addresses >= NUM_REGS are unmapped.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have port frame_active  input  1  SPI chip-select active, already synchronised to clk, high while selected.
REQ-006 SHALL have port byte_valid  input  1  one-clk pulse: byte_in holds a complete received byte.
REQ-007 SHALL have port byte_in  input  8  received byte, MSB-first assembled.
REQ-008 SHALL have port byte_out  output  8  next byte the SPI slave shifts out.
REQ-009 SHALL have port status_in  input  8  status byte returned as first response of every frame.
REQ-010 SHALL have port reg_raddr  output  ADDR_W  read address to register file (combinational read).
REQ-011 SHALL have port reg_rdata  input  8  register file read data, valid same cycle as reg_raddr.
REQ-012 SHALL have port reg_we, reg_waddr[ADDR_W-1:0], reg_wdata[7:0]  output  write strobe, address, data.
REQ-013 SHALL have port frame_done  output  1  one-clk pulse at frame end; frame_bytes  output  8  bytes received in that frame, saturating at 255.

Function
REQ-014 SHALL implement states IDLE, CMD, WRITE, READ, SKIP.
REQ-015 IDLE -> CMD only on a rising edge of frame_active (low in previous clk, high now); a frame already active out of reset SHALL be ignored until deselected.
REQ-016 In CMD, byte_valid latches command: bit7=1 read, bit7=0 write; bits[ADDR_W-1:0] start address; bits[6:ADDR_W] SHALL be ignored.
REQ-017 CMD -> READ on read command, CMD -> WRITE on write command, same edge as byte_valid.
REQ-018 In WRITE, each byte_valid SHALL pulse reg_we for exactly one clk the following cycle with reg_waddr = current address, reg_wdata = byte_in; address then increments.
REQ-019 Writes to unmapped addresses SHALL NOT assert reg_we; address still increments.
REQ-020 In READ, bytes received on MOSI SHALL be discarded; each byte_valid advances the address.
REQ-021 reg_raddr SHALL equal byte_in[ADDR_W-1:0] while in CMD, else the current address.
REQ-022 byte_out SHALL update exactly one clk after each byte_valid (required by slave load timing): in CMD with read command and in READ, byte_out <= reg_rdata (0x00 if the address is unmapped); otherwise byte_out <= 0x00.
REQ-023 Address SHALL wrap from 2^ADDR_W-1 to 0.
REQ-024 On frame_active falling: state -> IDLE, frame_done pulses one clk, frame_bytes holds the count until the next frame_done, byte_out <= status_in.
REQ-025 On IDLE -> CMD, byte_out <= status_in and byte counter clears.
REQ-026 byte_valid and frame_active fall in the same clk: byte SHALL be fully processed (write issued, count included), then IDLE.
REQ-027 byte_valid while frame_active is low, or in IDLE, SHALL be ignored and not counted.
REQ-028 SKIP SHALL be unused by valid traffic; any illegal state encoding SHALL recover to IDLE next clk.

Reset
REQ-029 While rst_n low at a clk edge: state IDLE, address 0, byte_out 0x00, reg_we 0, reg_waddr 0, reg_wdata 0x00, frame_done 0, frame_bytes 0, byte counter 0.
REQ-030 Reset mid-frame SHALL abort with no further reg_we pulses; the interrupted frame SHALL NOT produce frame_done.

Verification
REQ-031 Write burst: frame, bytes 0x05,0xAA,0xBB -> reg_we pulses at addr 5=0xAA, 6=0xBB; frame_done with frame_bytes=3.
REQ-032 Read burst: regs 10=0x11, 11=0x22; frame bytes 0x8A,0x00,0x00 -> byte_out sequence status_in, 0x11, 0x22, each 1 clk after byte_valid.
REQ-033 Wrap: write cmd 0x3F, data 0x01,0x02 with NUM_REGS=64 -> writes addr 63=0x01, addr 0=0x02.
REQ-034 Unmapped: read cmd 0xB0 (addr 48) -> byte_out 0x00; write cmd 0x30 + data -> no reg_we.
REQ-035 Simultaneous: last byte_valid coincident with frame_active fall -> write issued, frame_bytes includes it, state IDLE.
REQ-036 Reset mid-write after 1 data byte, frame_active held high -> no writes until frame_active low then high again; all outputs at reset values.
